memoria_datos_param: RTL and testbench
======================================

# memoria_datos_param

Parametrised data memory for the pipeline MEM stage, successor to the fixed 1K×32 word memory. It adds configurable width and depth, byte/half/word/dword accesses with byte-lane writes, and sign/zero extension on loads. Reads are registered with a one-cycle valid response, misaligned accesses are flagged, and read/write collision behaviour is selectable. It sits between the EX/MEM pipeline register and the MEM/WB write-back mux.

## Interface
Parameters:
- DATA_W, 32, word width in bits; legal values 32 or 64.
- ADDR_W, 12, byte-address width; depth = 2^ADDR_W / (DATA_W/8) words.
- INIT_WORD, 32'h0000_0004, value loaded into every word at elaboration (zero-extended to DATA_W).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W = 64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  response for the request of the previous cycle.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_error  out  1  previous request was misaligned or had an illegal size.
- err_sticky  out  1  set on any error, cleared only by reset.

## Operation
- Word index = req_addr[ADDR_W-1:log2(DATA_W/8)]; lane offset = low bits.
- Alignment rule: the address must be a multiple of the access size. dword with DATA_W = 32 is illegal.
- Store: byte lanes selected by size and offset; req_wdata low bits are replicated into the selected lanes; other lanes are unchanged.
- Load: the selected lanes are shifted down and extended per req_unsigned to DATA_W.
- Error request: no RAM write, rsp_rdata = 0, rsp_error = 1, err_sticky set.
- The RAM array is not cleared by reset; only INIT_WORD at elaboration sets its contents.
- There is no backpressure; a request is accepted every cycle.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_error 0, err_sticky 0. Reset is effective asynchronously; deassertion is sampled at the rising edge.
- Latency: request at edge N produces rsp_* valid after edge N+1, held for one cycle.
- rsp_valid = registered req_valid. When idle, rsp_rdata and rsp_error return to 0.
- Store commits to the array at the accept edge.
- Back-to-back store then load of the same word on consecutive cycles: the load sees the new data.
- Reset asserted mid-access: the pending response is dropped. A store sampled on the same edge as reset assertion is not guaranteed to commit.
- Extension and lane muxing are combinational before the output register; no combinational path from req_* to rsp_*.

## Configuration
- MEMDATOS_BYPASS_EN defined: same-cycle collision is not possible with one port. Instead, a load issued in the cycle immediately after a store to the same word returns merged data from a one-entry forwarding register (write-first semantics even if the array is implemented read-first). This is required for BRAM inference with registered writes.
- Undefined: no forwarding register; the array must be implemented so that the consecutive-cycle case still returns new data, i.e. distributed/write-through only.

## Structure
- Package memdatos_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - function lane_mask(size, offset);
  - function align_ok(size, offset, DATA_W);
  - function extend(data, size, unsigned).
- One sub-module: memdatos_ram, a plain array with per-byte write enables and a registered read, so that the storage can be swapped per target.

## Test plan
- Reset, then load word at 0x010 -> rsp_valid one cycle later, rsp_rdata = 0x0000_0004, rsp_error 0.
- Store byte 0xF0 at 0x021, then load signed byte 0x021 -> 0xFFFF_FFF0; unsigned -> 0x0000_00F0; word load 0x020 -> 0x0000_F004.
- Store half 0x8001 at 0x032, signed half load -> 0xFFFF_8001, word load 0x030 -> 0x8001_0004.
- Word load at 0x041 -> rsp_error 1, rdata 0, err_sticky 1; a later good access keeps err_sticky 1 until reset_n pulses low.
- Store word 0xDEAD_BEEF at 0x050 followed immediately by load 0x050 (with and without MEMDATOS_BYPASS_EN) -> 0xDEAD_BEEF both builds.
- DATA_W = 64: dword store 0x0123_4567_89AB_CDEF at 0x008, load -> same value; dword with DATA_W = 32 -> rsp_error 1.

Source files
------------

// File: rtl/memdatos_pkg.sv
// Shared encodings and lane/extension helpers for memoria_datos_param.
// Helpers work on 64-bit containers; callers truncate to their DATA_W.
package memdatos_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_BYTES = MAX_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  // Control carried alongside the read data into the response stage
  typedef struct packed {
    logic       load;
    logic       err;
    size_e      size;
    logic       zero_ext;
    logic [2:0] offset;
  } rsp_ctl_t;

  function automatic logic [MAX_BYTES-1:0] lane_mask(size_e size, logic [2:0] offset);
    logic [MAX_BYTES-1:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic align_ok(size_e size, logic [2:0] offset, int unsigned data_w);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (offset[0] == 1'b0);
      SZ_WORD: ok = (offset[1:0] == 2'b00);
      default: ok = (data_w == 64) && (offset == 3'b000);
    endcase
    return ok;
  endfunction

  // Copy the low bits of store data into every lane of the access size
  function automatic logic [MAX_W-1:0] replicate(logic [MAX_W-1:0] data, size_e size);
    logic [MAX_W-1:0] r;
    case (size)
      SZ_BYTE: r = {8{data[7:0]}};
      SZ_HALF: r = {4{data[15:0]}};
      SZ_WORD: r = {2{data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] extend(logic [MAX_W-1:0] data, size_e size, logic zero_ext);
    logic [MAX_W-1:0] r;
    case (size)
      SZ_BYTE: r = {{56{~zero_ext & data[7]}},  data[7:0]};
      SZ_HALF: r = {{48{~zero_ext & data[15]}}, data[15:0]};
      SZ_WORD: r = {{32{~zero_ext & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memdatos_ram.sv
// Storage array: per-byte write enables, registered read (read-first on a shared index).
// Contents come only from INIT_WORD at elaboration; reset does not touch them.
module memdatos_ram #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 10,
  parameter logic [31:0] INIT_WORD = 32'h0000_0004
) (
  input  logic                  clk,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: DATA_W'(INIT_WORD)};

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/memoria_datos_param.sv
// MEM-stage data memory: sized/aligned loads and stores, one-cycle registered response.
// Optional MEMDATOS_BYPASS_EN: registered array writes plus a one-entry forwarding register.
module memoria_datos_param
  import memdatos_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] INIT_WORD = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              err_sticky
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;

  size_e             size_c;
  logic [2:0]        off_c;
  logic [IDX_W-1:0]  idx_c;
  logic              acc_ok_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [BYTES-1:0]  wr_be_c;
  logic [DATA_W-1:0] wdata_c;

  // Request decode
  assign size_c   = size_e'(req_size);
  assign off_c    = 3'(req_addr[OFF_W-1:0]);
  assign idx_c    = req_addr[ADDR_W-1:OFF_W];
  assign acc_ok_c = align_ok(size_c, off_c, DATA_W);
  assign wr_en_c  = req_valid & req_write & acc_ok_c;
  assign rd_en_c  = req_valid & ~req_write & acc_ok_c;
  assign wr_be_c  = {BYTES{wr_en_c}} & BYTES'(lane_mask(size_c, off_c));
  assign wdata_c  = DATA_W'(replicate(64'(req_wdata), size_c));

  logic [BYTES-1:0]  ram_we;
  logic [IDX_W-1:0]  ram_widx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] merged_c;

  memdatos_ram #(
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .INIT_WORD (INIT_WORD)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .widx  (ram_widx),
    .wdata (ram_wdata),
    .re    (rd_en_c),
    .ridx  (idx_c),
    .rdata (ram_q)
  );

`ifdef MEMDATOS_BYPASS_EN
  logic [BYTES-1:0]  pend_we;
  logic [IDX_W-1:0]  pend_idx;
  logic [DATA_W-1:0] pend_data;
  logic [BYTES-1:0]  fwd_be;
  logic [DATA_W-1:0] fwd_data;

  // Store lands in the array one edge late; a load that reads on that edge sees old data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_we <= '0;
      fwd_be  <= '0;
    end else begin
      pend_we <= wr_be_c;
      fwd_be  <= (rd_en_c && (pend_idx == idx_c)) ? pend_we : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      pend_idx  <= idx_c;
      pend_data <= wdata_c;
    end
    fwd_data <= pend_data;
  end

  assign ram_we    = pend_we;
  assign ram_widx  = pend_idx;
  assign ram_wdata = pend_data;

  always_comb begin
    merged_c = ram_q;
    for (int b = 0; b < BYTES; b++) begin
      if (fwd_be[b]) merged_c[b*8 +: 8] = fwd_data[b*8 +: 8];
    end
  end
`else
  assign ram_we    = wr_be_c;
  assign ram_widx  = idx_c;
  assign ram_wdata = wdata_c;
  assign merged_c  = ram_q;
`endif

  rsp_ctl_t ctl_q;

  // Response control pipeline; the array read register carries the data half
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      ctl_q      <= '0;
      err_sticky <= 1'b0;
    end else begin
      rsp_valid      <= req_valid;
      ctl_q.load     <= rd_en_c;
      ctl_q.err      <= req_valid & ~acc_ok_c;
      ctl_q.size     <= size_c;
      ctl_q.zero_ext <= req_unsigned;
      ctl_q.offset   <= off_c;
      err_sticky     <= err_sticky | (req_valid & ~acc_ok_c);
    end
  end

  assign rsp_error = ctl_q.err;

  logic [63:0] shifted_c;

  // Lane select and extension from registered state only
  always_comb begin
    rsp_rdata = '0;
    shifted_c = 64'(merged_c) >> {ctl_q.offset, 3'b000};
    if (ctl_q.load) rsp_rdata = DATA_W'(extend(shifted_c, ctl_q.size, ctl_q.zero_ext));
  end

endmodule

// File: tb/tb_memoria_datos_param.sv
// Directed bench for memoria_datos_param: 32-bit default instance plus a 64-bit instance.
module tb_memoria_datos_param;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_valid, a_write, a_uns;
  logic [1:0]  a_size;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_rvalid, a_err, a_sticky;
  logic [31:0] a_rdata;

  logic        b_valid, b_write, b_uns;
  logic [1:0]  b_size;
  logic [11:0] b_addr;
  logic [63:0] b_wdata;
  logic        b_rvalid, b_err, b_sticky;
  logic [63:0] b_rdata;

  memoria_datos_param u_dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (a_valid),
    .req_write    (a_write),
    .req_size     (a_size),
    .req_unsigned (a_uns),
    .req_addr     (a_addr),
    .req_wdata    (a_wdata),
    .rsp_valid    (a_rvalid),
    .rsp_rdata    (a_rdata),
    .rsp_error    (a_err),
    .err_sticky   (a_sticky)
  );

  memoria_datos_param #(.DATA_W(64), .ADDR_W(12)) u_dut64 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (b_valid),
    .req_write    (b_write),
    .req_size     (b_size),
    .req_unsigned (b_uns),
    .req_addr     (b_addr),
    .req_wdata    (b_wdata),
    .rsp_valid    (b_rvalid),
    .rsp_rdata    (b_rdata),
    .rsp_error    (b_err),
    .err_sticky   (b_sticky)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request, then step to the next falling edge where its response is visible
  task automatic op32(input logic w, input logic [1:0] sz, input logic u,
                      input logic [11:0] ad, input logic [31:0] wd);
    a_valid = 1'b1; a_write = w; a_size = sz; a_uns = u; a_addr = ad; a_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle32();
    a_valid = 1'b0; a_write = 1'b0; a_size = 2'b00; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
    @(negedge clk);
  endtask

  task automatic op64(input logic w, input logic [1:0] sz, input logic u,
                      input logic [11:0] ad, input logic [63:0] wd);
    b_valid = 1'b1; b_write = w; b_size = sz; b_uns = u; b_addr = ad; b_wdata = wd;
    @(negedge clk);
  endtask

  task automatic load32(input string tag, input logic [1:0] sz, input logic u,
                        input logic [11:0] ad, input logic [31:0] exp);
    op32(1'b0, sz, u, ad, 32'h0);
    check({tag, "_valid"}, 64'(a_rvalid), 64'd1);
    check({tag, "_err"},   64'(a_err),    64'd0);
    check({tag, "_data"},  64'(a_rdata),  64'(exp));
  endtask

  task automatic err32(input string tag, input logic w, input logic [1:0] sz,
                       input logic [11:0] ad, input logic [31:0] wd);
    op32(w, sz, 1'b0, ad, wd);
    check({tag, "_err"},    64'(a_err),    64'd1);
    check({tag, "_data"},   64'(a_rdata),  64'd0);
    check({tag, "_sticky"}, 64'(a_sticky), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_size = 2'b00; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_size = 2'b00; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valid",  64'(a_rvalid), 64'd0);
    check("rst_rdata",  64'(a_rdata),  64'd0);
    check("rst_error",  64'(a_err),    64'd0);
    check("rst_sticky", 64'(a_sticky), 64'd0);
    check("rst_valid64", 64'(b_rvalid), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    load32("ld_init", 2'b10, 1'b0, 12'h010, 32'h0000_0004);
    idle32();
    check("idle_valid", 64'(a_rvalid), 64'd0);
    check("idle_rdata", 64'(a_rdata),  64'd0);

    op32(1'b1, 2'b00, 1'b0, 12'h021, 32'h0000_00F0);
    check("st_b_valid", 64'(a_rvalid), 64'd1);
    check("st_b_rdata", 64'(a_rdata),  64'd0);
    load32("ld_bs",  2'b00, 1'b0, 12'h021, 32'hFFFF_FFF0);
    load32("ld_bu",  2'b00, 1'b1, 12'h021, 32'h0000_00F0);
    load32("ld_w20", 2'b10, 1'b0, 12'h020, 32'h0000_F004);
    load32("ld_bpos", 2'b00, 1'b0, 12'h020, 32'h0000_0004);

    op32(1'b1, 2'b01, 1'b0, 12'h032, 32'h0000_8001);
    load32("ld_hs",  2'b01, 1'b0, 12'h032, 32'hFFFF_8001);
    load32("ld_hu",  2'b01, 1'b1, 12'h032, 32'h0000_8001);
    load32("ld_w30", 2'b10, 1'b0, 12'h030, 32'h8001_0004);

    // Half store replicates only the low 16 bits into its two lanes
    op32(1'b1, 2'b01, 1'b0, 12'h070, 32'hFFFF_1234);
    load32("ld_w70", 2'b10, 1'b0, 12'h070, 32'h0000_1234);

    err32("mis_w41", 1'b0, 2'b10, 12'h041, 32'h0);
    err32("mis_h43", 1'b0, 2'b01, 12'h043, 32'h0);
    err32("mis_st62", 1'b1, 2'b10, 12'h062, 32'h1234_5678);
    load32("ld_w60", 2'b10, 1'b0, 12'h060, 32'h0000_0004);
    check("sticky_hold", 64'(a_sticky), 64'd1);
    err32("dword32", 1'b0, 2'b11, 12'h000, 32'h0);

    // Back-to-back store then load of the same word
    op32(1'b1, 2'b10, 1'b0, 12'h050, 32'hDEAD_BEEF);
    load32("b2b_w", 2'b10, 1'b0, 12'h050, 32'hDEAD_BEEF);
    op32(1'b1, 2'b00, 1'b0, 12'h053, 32'h1234_56AA);
    load32("b2b_b", 2'b00, 1'b1, 12'h053, 32'h0000_00AA);
    load32("ld_w50", 2'b10, 1'b0, 12'h050, 32'hAAAD_BEEF);
    op32(1'b1, 2'b10, 1'b0, 12'h054, 32'h1111_1111);
    load32("b2b_other", 2'b10, 1'b0, 12'h050, 32'hAAAD_BEEF);
    load32("ld_w54", 2'b10, 1'b0, 12'h054, 32'h1111_1111);
    idle32();
    check("sticky_idle", 64'(a_sticky), 64'd1);

    reset_n = 1'b0;
    #1;
    check("rst2_sticky", 64'(a_sticky), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load32("keep_ram", 2'b10, 1'b0, 12'h050, 32'hAAAD_BEEF);
    check("sticky_clr", 64'(a_sticky), 64'd0);

    // Reset landing while a response is being presented drops it
    a_valid = 1'b1; a_write = 1'b0; a_size = 2'b10; a_addr = 12'h010;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(a_rvalid), 64'd0);
    check("midrst_rdata", 64'(a_rdata),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle32();

    op64(1'b1, 2'b11, 1'b0, 12'h008, 64'h0123_4567_89AB_CDEF);
    op64(1'b0, 2'b11, 1'b0, 12'h008, 64'h0);
    check("d64_valid", 64'(b_rvalid), 64'd1);
    check("d64_err",   64'(b_err),    64'd0);
    check("d64_data",  b_rdata,       64'h0123_4567_89AB_CDEF);
    op64(1'b0, 2'b10, 1'b1, 12'h00C, 64'h0);
    check("w64_hi_u", b_rdata, 64'h0000_0000_0123_4567);
    op64(1'b0, 2'b10, 1'b0, 12'h008, 64'h0);
    check("w64_lo_s", b_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    op64(1'b0, 2'b11, 1'b0, 12'h000, 64'h0);
    check("d64_init", b_rdata, 64'h0000_0000_0000_0004);
    op64(1'b0, 2'b11, 1'b0, 12'h004, 64'h0);
    check("d64_mis_err",    64'(b_err),    64'd1);
    check("d64_mis_data",   b_rdata,       64'd0);
    check("d64_mis_sticky", 64'(b_sticky), 64'd1);
    b_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
